// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Front end for an sr_flipflop. Accepts set/reset commands over a valid/ready
//   handshake and turns each one into a registered s or r pulse of HOLD_CYCLES,
//   followed by GUARD_CYCLES of s=r=0. Commands the flip-flop already satisfies
//   (judged from q_fb at accept time) complete immediately without a pulse.
//
//   Ports
//     clk        in   clock, all logic on posedge
//     rst        in   synchronous active-high reset
//     req_valid  in   command valid
//     req_set    in   command requests q=1
//     req_reset  in   command requests q=0
//     req_ready  out  command can be accepted this cycle (IDLE)
//     q_fb       in   q from the downstream flip-flop
//     s          out  registered set drive
//     r          out  registered reset drive
//     busy       out  high in DRIVE or GUARD
//     done       out  one-cycle pulse when a command completes
//     conflict   out  one-cycle pulse when an accepted command had set and reset both high
//
//   state | meaning
//   IDLE  | waiting for a command, req_ready high
//   DRIVE | s or r held high, counter counts down the hold time
//   GUARD | s=r=0, counter counts down the gap before the next accept
module sr_cmd_sequencer #(
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned GUARD_CYCLES = 1,
    parameter int unsigned CNT_W        = 4,
    parameter bit          SET_PRIORITY = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    input  logic req_reset,
    output logic req_ready,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic conflict
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYCLES == 0) ? '0 : CNT_W'(GUARD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             done_q, done_d;
    logic             conflict_q, conflict_d;

    logic accept;
    logic want_set;
    logic want_rst;
    logic tgt_met;
    logic start;
    logic cnt_zero;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign conflict  = conflict_q;

    assign accept   = req_valid & req_ready;
    // Priority resolution makes want_set and want_rst mutually exclusive,
    // which is what keeps s and r from ever being high together.
    assign want_set = req_set & (~req_reset | SET_PRIORITY);
    assign want_rst = req_reset & (~req_set | ~SET_PRIORITY);
    assign tgt_met  = (want_set & q_fb) | (want_rst & ~q_fb);
    assign start    = accept & (want_set | want_rst) & ~tgt_met;
    assign cnt_zero = (cnt_q == '0);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    // Next state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_DRIVE: begin
                if (cnt_zero) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = GUARD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        s_d        = s_q;
        r_d        = r_q;
        conflict_d = accept & req_set & req_reset;
        // Completion: either an already-satisfied command, or the first IDLE
        // cycle after a pulse sequence.
        done_d     = (accept & tgt_met) | ((state_q != ST_IDLE) & (state_d == ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d = want_set;
                    r_d = want_rst;
                end
            end
            ST_DRIVE: begin
                if (cnt_zero) begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end
            end
            default: begin
                s_d = 1'b0;
                r_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
module tb_sr_cmd_sequencer;

    localparam int H = 2;
    localparam int G = 1;

    logic clk;
    logic rst;
    logic req_valid, req_set, req_reset, req_ready, q_fb;
    logic s, r, busy, done, conflict;

    // second instance with reset priority, used for a short directed check
    logic rp_valid, rp_set, rp_reset, rp_ready, rp_qfb;
    logic rp_s, rp_r, rp_busy, rp_done, rp_conflict;

    sr_cmd_sequencer #(.HOLD_CYCLES(H), .GUARD_CYCLES(G), .CNT_W(4), .SET_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_reset(req_reset),
        .req_ready(req_ready), .q_fb(q_fb), .s(s), .r(r), .busy(busy), .done(done),
        .conflict(conflict)
    );

    sr_cmd_sequencer #(.HOLD_CYCLES(H), .GUARD_CYCLES(G), .CNT_W(4), .SET_PRIORITY(1'b0)) dut_rp (
        .clk(clk), .rst(rst), .req_valid(rp_valid), .req_set(rp_set), .req_reset(rp_reset),
        .req_ready(rp_ready), .q_fb(rp_qfb), .s(rp_s), .r(rp_r), .busy(rp_busy), .done(rp_done),
        .conflict(rp_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of posedges so far

    always @(posedge clk) cyc <= cyc + 1;

    // downstream sr_flipflop plant
    logic q_ff = 1'b0;
    always @(posedge clk) begin
        if (s)      q_ff <= 1'b1;
        else if (r) q_ff <= 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // expected response of one accepted command
    typedef struct {
        int done_edge;   // posedge after which done is high
        int s_len;
        int r_len;
        int conf;
        int first_edge;  // posedge after which the pulse starts, -1 if none
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    int next_free = 0;   // earliest posedge at which a command can be accepted
    bit q_model   = 1'b0;

    // monitor: observes at negedge, pops on done
    int s_cnt = 0, r_cnt = 0, conf_cnt = 0, first_edge = -1;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_s", s, 0);
            chk("rst_r", r, 0);
            chk("rst_done", done, 0);
            chk("rst_conflict", conflict, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 1);
            s_cnt = 0; r_cnt = 0; conf_cnt = 0; first_edge = -1;
        end else begin
            chk("s_and_r", s & r, 0);
            if ((s || r) && s_cnt == 0 && r_cnt == 0) first_edge = cyc;
            if (s) s_cnt++;
            if (r) r_cnt++;
            if (conflict) conf_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_edge", cyc, e.done_edge);
                    chk("s_len", s_cnt, e.s_len);
                    chk("r_len", r_cnt, e.r_len);
                    chk("conflict_cnt", conf_cnt, e.conf);
                    chk("pulse_start", first_edge, e.first_edge);
                end
                s_cnt = 0; r_cnt = 0; conf_cnt = 0; first_edge = -1;
            end
        end
    end

    // one stimulus period; acc reports whether the model expects acceptance
    task automatic step(input bit v, input bit st, input bit rs, output bit acc);
        bit exp_rdy;
        int tgt;
        exp_t e;
        @(negedge clk); #1;
        req_valid = v; req_set = st; req_reset = rs;
        exp_rdy = (cyc + 1 >= next_free);
        chk("ready", req_ready, exp_rdy);
        chk("busy", busy, !exp_rdy);
        if (exp_rdy) begin
            chk("q_plant", q_ff, q_model);
            q_fb = q_ff;
        end else begin
            q_fb = 1'($urandom_range(0, 1));   // must be ignored while busy
        end
        acc = v && exp_rdy;
        if (acc) begin
            if (st && !rs)      tgt = 1;
            else if (rs && !st) tgt = 0;
            else if (st && rs)  tgt = 1;   // set wins
            else                tgt = -1;
            if (tgt < 0) begin
                next_free = cyc + 2;
            end else if (tgt == int'(q_model)) begin
                e = '{done_edge: cyc + 1, s_len: 0, r_len: 0, conf: int'(st & rs), first_edge: -1};
                exp_q.push_back(e);
                next_free = cyc + 2;
            end else begin
                e = '{done_edge: cyc + 1 + H + G, s_len: (tgt == 1) ? H : 0,
                      r_len: (tgt == 0) ? H : 0, conf: int'(st & rs), first_edge: cyc + 1};
                exp_q.push_back(e);
                next_free = cyc + 2 + H + G;
                q_model = (tgt == 1);
            end
        end
    endtask

    task automatic send(input bit st, input bit rs);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(1'b1, st, rs, acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    // abort: a pulse already started has reached the plant, so q_model stays
    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst = 1'b1; req_valid = 1'b1; req_set = 1'b1; req_reset = 1'b0; q_fb = q_ff;
        exp_q.delete();
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        next_free = cyc + 1;
    endtask

    initial begin
        bit acc, pv, ps, pr, need_new;
        rst = 1'b1; req_valid = 1'b1; req_set = 1'b1; req_reset = 1'b0; q_fb = 1'b0;
        rp_valid = 1'b0; rp_set = 1'b0; rp_reset = 1'b0; rp_qfb = 1'b1;

        // reset held two cycles with a command pending
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        next_free = cyc + 1;

        // directed sequence through the scoreboard
        send(1, 0);   // q=0: s pulse
        send(1, 0);   // q=1: skip
        send(1, 1);   // q=1, both: skip with conflict
        send(0, 1);   // r pulse
        send(1, 0);   // back to back: s then r, held valid
        send(0, 1);
        send(0, 0);   // no-op
        send(1, 0);   // pulse, then reset in its first drive cycle
        do_reset(1);
        send(0, 1);   // accepted normally after abort
        step(0, 0, 0, acc);

        // reset-priority instance: both requests with q=1 -> r pulse
        @(negedge clk); #1;
        req_valid = 1'b0;
        chk("rp_ready", rp_ready, 1);
        rp_valid = 1'b1; rp_set = 1'b1; rp_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            rp_valid = 1'b0;
            chk("rp_r", rp_r, (k < 2) ? 1 : 0);
            chk("rp_s", rp_s, 0);
            chk("rp_conflict", rp_conflict, (k == 0) ? 1 : 0);
            chk("rp_done", rp_done, (k == 3) ? 1 : 0);
        end

        // random traffic with held-valid handshake and occasional resets
        need_new = 1'b1;
        pv = 1'b0; ps = 1'b0; pr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (need_new) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 1'($urandom_range(0, 1));
                pr = 1'($urandom_range(0, 1));
            end
            step(pv, ps, pr, acc);
            need_new = acc || !pv;
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2));
                need_new = 1'b1;
            end
        end

        // drain
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 0, 0, acc);
        chk("drain_empty", exp_q.size(), 0);
        step(0, 0, 0, acc);
        chk("leftover_pulse", s_cnt + r_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
